// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction-bus fetcher feeding a prefetch FIFO that drives IF/ID.
// Define FETCH_QUEUE_PERF_EN to add saturating perf counters (perf_fetched/perf_discarded/perf_full_cycles).

package fetch_queue_pkg;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] instrAddr;
        logic [63:0] pcPlus4;
    } REG_IF_ID;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [63:0] PC_RESET   = 64'h8000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        ok_to_proceed_overall,
    input  ibus_resp_t  ibus_resp,
    output ibus_req_t   ibus_req,
    output REG_IF_ID    moduleOut,
    output logic        ok_to_proceed
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_discarded,
    output logic [63:0] perf_full_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] addr;
    } entry_t;

    state_e           state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic             req_valid_q, req_valid_d;
    logic [63:0]      req_addr_q, req_addr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_after;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head_entry;

    logic complete;
    logic head_valid;
    logic pop;
    logic push;
    logic discard;

    always_comb begin
        complete    = req_valid_q & ibus_resp.addr_ok & ibus_resp.data_ok;
        head_valid  = (count_q != '0);
        pop         = head_valid & ok_to_proceed_overall;
        // A completion is kept only in REQ and only when no redirect arrives with it.
        push        = (state_q == REQ) & complete & ~redirect_valid;
        discard     = complete & ((state_q == DRAIN) | redirect_valid);
        count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_after;
        end

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d  = redirect_pc;
                    req_valid_d = 1'b1;
                    req_addr_d  = redirect_pc;
                    state_d     = REQ;
                end else if ((count_q < DEPTH_C) || pop) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = fetch_pc_q;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    if (complete) begin
                        req_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (complete) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    if (count_after < DEPTH_C) begin
                        req_addr_d = fetch_pc_q + 64'd4;
                    end else begin
                        req_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) fetch_pc_d = redirect_pc;
                if (complete) begin
                    req_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                req_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= PC_RESET;
            req_valid_q <= 1'b0;
            req_addr_q  <= PC_RESET;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the entry array has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{instr: ibus_resp.data, addr: fetch_pc_q};
    end

    assign head_entry = mem_q[head_q];

    always_comb begin
        ibus_req.valid      = req_valid_q;
        ibus_req.addr       = req_addr_q;
        moduleOut.valid     = head_valid;
        moduleOut.instr     = head_entry.instr;
        moduleOut.instrAddr = head_entry.addr;
        moduleOut.pcPlus4   = head_entry.addr + 64'd4;
        ok_to_proceed       = head_valid;
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [63:0] perf_fetched_q, perf_fetched_d;
    logic [63:0] perf_discarded_q, perf_discarded_d;
    logic [63:0] perf_full_cycles_q, perf_full_cycles_d;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[64] ? '1 : sum[63:0];
    endfunction

    // Flushed entries count as discarded along with any completion dropped by DRAIN or redirect.
    always_comb begin
        perf_fetched_d     = sat_add(perf_fetched_q, 64'(push));
        perf_discarded_d   = sat_add(perf_discarded_q,
                                     64'(discard) + (redirect_valid ? 64'(count_q) : 64'd0));
        perf_full_cycles_d = sat_add(perf_full_cycles_q, 64'(count_q == DEPTH_C));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q     <= '0;
            perf_discarded_q   <= '0;
            perf_full_cycles_q <= '0;
        end else begin
            perf_fetched_q     <= perf_fetched_d;
            perf_discarded_q   <= perf_discarded_d;
            perf_full_cycles_q <= perf_full_cycles_d;
        end
    end

    assign perf_fetched     = perf_fetched_q;
    assign perf_discarded   = perf_discarded_q;
    assign perf_full_cycles = perf_full_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: latency-programmable bus responder, queue-based
// reference model of the delivered instruction stream, directed scenarios plus random traffic.

module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam logic [63:0] PC_RESET = 64'h8000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        adv;
    ibus_resp_t  ibus_resp;
    ibus_req_t   ibus_req;
    REG_IF_ID    module_out;
    logic        ok_to_proceed;
`ifdef FETCH_QUEUE_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_discarded;
    logic [63:0] perf_full_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat_min  = 0;
    int lat_max  = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_pc;
    logic        stale;
    logic        after_rst;
    logic        prev_pending;
    logic [63:0] prev_addr;
    logic [63:0] m_fetched;
    logic [63:0] m_discarded;
    logic [63:0] m_full;
    int          n_popped;

    fetch_queue #(
        .PC_RESET   (PC_RESET),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .ok_to_proceed_overall (adv),
        .ibus_resp             (ibus_resp),
        .ibus_req              (ibus_req),
        .moduleOut             (module_out),
        .ok_to_proceed         (ok_to_proceed)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched          (perf_fetched),
        .perf_discarded        (perf_discarded),
        .perf_full_cycles      (perf_full_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: completes each request after lat cycles; before that it may raise
    // addr_ok or data_ok alone, which must not count as a transfer.
    initial begin : bus
        int          cnt;
        int          lat;
        logic        last_valid;
        logic        last_ok;
        logic        last_rst;
        logic        ok;
        logic [1:0]  pat;
        ibus_resp  = '0;
        cnt        = 0;
        lat        = 0;
        last_valid = 1'b0;
        last_ok    = 1'b0;
        last_rst   = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (last_rst || !last_valid || last_ok) begin
                cnt = 0;
                lat = int'($urandom_range(lat_max, lat_min));
            end else begin
                cnt++;
            end
            ok  = ibus_req.valid && (cnt >= lat);
            pat = 2'($urandom_range(2, 0));
            ibus_resp.addr_ok = ok | (pat == 2'd1);
            ibus_resp.data_ok = ok | (pat == 2'd2);
            ibus_resp.data    = ok ? instr_of(ibus_req.addr) : $urandom;
            last_valid = ibus_req.valid;
            last_ok    = ok;
            last_rst   = rst;
        end
    end

    // Scoreboard: exp_q holds what the IF/ID consumer must see; compared on every negedge.
    initial begin : monitor
        logic hs;
        int   sz;
        exp_q.delete();
        exp_pc       = PC_RESET;
        stale        = 1'b0;
        after_rst    = 1'b1;
        prev_pending = 1'b0;
        prev_addr    = '0;
        m_fetched    = '0;
        m_discarded  = '0;
        m_full       = '0;
        n_popped     = 0;
        forever begin
            @(negedge clk);
            sz = exp_q.size();
            check("out_valid", module_out.valid, sz != 0);
            check("ok_to_proceed", ok_to_proceed, sz != 0);
            if (sz != 0) begin
                check("out_instrAddr", module_out.instrAddr, exp_q[0].addr);
                check("out_instr", module_out.instr, exp_q[0].instr);
                check("out_pcPlus4", module_out.pcPlus4, exp_q[0].addr + 64'd4);
            end
            if (after_rst) begin
                check("req_valid_after_reset", ibus_req.valid, 0);
                check("req_addr_after_reset", ibus_req.addr, PC_RESET);
            end
            if (prev_pending) begin
                check("req_held_valid", ibus_req.valid, 1);
                check("req_held_addr", ibus_req.addr, prev_addr);
            end
            if (ibus_req.valid && !stale) check("req_addr", ibus_req.addr, exp_pc);
`ifdef FETCH_QUEUE_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_discarded", perf_discarded, m_discarded);
            check("perf_full_cycles", perf_full_cycles, m_full);
`endif
            hs = ibus_req.valid & ibus_resp.addr_ok & ibus_resp.data_ok;
            if (rst) begin
                exp_q.delete();
                exp_pc       = PC_RESET;
                stale        = 1'b0;
                prev_pending = 1'b0;
                m_fetched    = '0;
                m_discarded  = '0;
                m_full       = '0;
            end else begin
                if (sz == DEPTH) m_full++;
                if (redirect_valid) begin
                    m_discarded += 64'(sz);
                    exp_q.delete();
                    if (hs) begin
                        m_discarded++;
                        stale = 1'b0;
                    end else if (ibus_req.valid) begin
                        stale = 1'b1;
                    end
                    exp_pc = redirect_pc;
                end else begin
                    if (sz != 0 && adv) begin
                        void'(exp_q.pop_front());
                        n_popped++;
                    end
                    if (hs) begin
                        if (stale) begin
                            m_discarded++;
                            stale = 1'b0;
                        end else begin
                            check("slot_free", exp_q.size() < DEPTH, 1);
                            exp_q.push_back('{addr: exp_pc, instr: instr_of(exp_pc)});
                            m_fetched++;
                            exp_pc += 64'd4;
                        end
                    end
                end
                prev_pending = ibus_req.valid && !hs;
            end
            prev_addr = ibus_req.addr;
            after_rst = rst;
        end
    end

    task automatic drive(input logic a, input logic rv, input logic [63:0] rp);
        @(posedge clk);
        #1;
        adv            = a;
        redirect_valid = rv;
        redirect_pc    = rp;
    endtask

    task automatic do_reset(input logic a);
        @(posedge clk);
        #1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        adv            = a;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        adv            = 1'b0;

        // Reset values and back-to-back stream with a zero-latency bus.
        lat_min = 0;
        lat_max = 0;
        do_reset(1'b1);
        check("reset_out_valid", module_out.valid, 0);
        check("reset_ok_to_proceed", ok_to_proceed, 0);
        check("reset_req_valid", ibus_req.valid, 0);
        check("reset_req_addr", ibus_req.addr, PC_RESET);
        for (int i = 0; i < 10 && !module_out.valid; i++) @(negedge clk);
        check("stream_first_valid", module_out.valid, 1);
        check("stream_addr0", module_out.instrAddr, 64'h8000_0000);
        @(negedge clk);
        check("stream_valid1", module_out.valid, 1);
        check("stream_addr1", module_out.instrAddr, 64'h8000_0004);
        @(negedge clk);
        check("stream_valid2", module_out.valid, 1);
        check("stream_addr2", module_out.instrAddr, 64'h8000_0008);

        // FIFO fills to DEPTH with no consumer, then one pop triggers exactly one refetch.
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        check("full_req_idle", ibus_req.valid, 0);
        check("full_ok_to_proceed", ok_to_proceed, 1);
        check("full_head", module_out.instrAddr, 64'h8000_0000);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        check("refetch_valid", ibus_req.valid, 1);
        check("refetch_addr", ibus_req.addr, 64'h8000_0010);
        check("refetch_head", module_out.instrAddr, 64'h8000_0004);
        repeat (3) @(negedge clk);
        check("refull_req_idle", ibus_req.valid, 0);

        // Redirect while a slow request is pending: stale completion drained and dropped.
        lat_min = 3;
        lat_max = 3;
        do_reset(1'b1);
        for (int i = 0; i < 10 && !ibus_req.valid; i++) @(negedge clk);
        check("drain_req_seen", ibus_req.valid, 1);
        drive(1'b1, 1'b1, 64'h8000_1000);
        drive(1'b1, 1'b0, '0);
        @(negedge clk);
        check("drain_req_held", ibus_req.valid, 1);
        check("drain_req_addr_stale", ibus_req.addr, 64'h8000_0000);
        check("drain_out_empty", module_out.valid, 0);
        for (int i = 0; i < 30 && !module_out.valid; i++) @(negedge clk);
        check("drain_next_valid", module_out.valid, 1);
        check("drain_next_addr", module_out.instrAddr, 64'h8000_1000);

        // Redirect coinciding with a completion while two entries are queued.
        lat_min = 0;
        lat_max = 0;
        do_reset(1'b0);
        for (int i = 0; i < 10 && !module_out.valid; i++) @(negedge clk);
        check("rdc_first_valid", module_out.valid, 1);
        drive(1'b0, 1'b1, 64'h8000_2000);
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        check("rdc_fifo_empty", module_out.valid, 0);
        check("rdc_ok_to_proceed", ok_to_proceed, 0);
        check("rdc_req_idle", ibus_req.valid, 0);
        @(negedge clk);
        check("rdc_req_valid", ibus_req.valid, 1);
        check("rdc_req_addr", ibus_req.addr, 64'h8000_2000);

        // Reset asserted in the middle of a request with entries queued.
        lat_min = 2;
        lat_max = 2;
        do_reset(1'b0);
        for (int i = 0; i < 20 && !(module_out.valid && ibus_req.valid); i++) @(negedge clk);
        check("rmid_setup", module_out.valid && ibus_req.valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rmid_req_valid", ibus_req.valid, 0);
        check("rmid_out_valid", module_out.valid, 0);
        for (int i = 0; i < 10 && !ibus_req.valid; i++) @(negedge clk);
        check("rmid_first_addr", ibus_req.addr, PC_RESET);

        // 64-bit wrap of fetch_pc and pcPlus4.
        lat_min = 0;
        lat_max = 0;
        do_reset(1'b1);
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 20 && !(module_out.valid && module_out.instrAddr == 64'hFFFF_FFFF_FFFF_FFFC); i++)
            @(negedge clk);
        check("wrap_last_addr", module_out.instrAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pcPlus4", module_out.pcPlus4, 64'h0);
        @(negedge clk);
        check("wrap_next_addr", module_out.instrAddr, 64'h0);

        // Random traffic against the reference model.
        lat_min = 0;
        lat_max = 3;
        do_reset(1'b1);
        n_popped = 0;
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            adv = ((i / 200) % 3 == 0) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            case ($urandom_range(3, 0))
                0:       redirect_pc = {$urandom, $urandom} & ~64'h3;
                1:       redirect_pc = {$urandom, $urandom};
                2:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3, 0) * 4);
                default: redirect_pc = PC_RESET + 64'($urandom_range(63, 0) * 4);
            endcase
            rst = ($urandom_range(399, 0) == 0);
        end
        drive(1'b1, 1'b0, '0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("random_progress", n_popped > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
